dst_pipe: RTL and testbench
===========================

# dst_pipe

Destination-register tracking pipeline that consumes the 32-bit destination selected by `mux_dst` in the decode stage. It carries the destination and its write-enable through the EX, MEM and WB stages, with stall-bubble and flush support, and exposes the per-stage values to the writeback path. It also produces combinational forwarding selects for the two source operands of the instruction currently in decode, and counts inserted bubbles for debug.

## Interface
Parameters:
- `WIDTH`, default 32: width of the destination field carried per stage.
- `REGW`, default 5: number of low bits of the destination used as the register index for compares.
- `CNTW`, default 8: width of the bubble counter.

Ports:
- `clk`  in  1  system clock. All state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `dst_in`  in  WIDTH  destination from `mux_dst` (`out`).
- `wen_in`  in  1  register-write enable of the decoding instruction.
- `stall`  in  1  insert a bubble into EX this cycle.
- `flush`  in  1  kill the EX and MEM contents this cycle.
- `src_a`  in  REGW  rs index of the decoding instruction.
- `src_b`  in  REGW  rt index of the decoding instruction.
- `dst_ex`, `dst_mem`, `dst_wb`  out  WIDTH  registered destination per stage.
- `wen_ex`, `wen_mem`, `wen_wb`  out  1  registered write-enable per stage.
- `fwd_a`, `fwd_b`  out  2  forwarding select. 00 = register file, 01 = EX, 10 = MEM, 11 = WB.
- `bubble_cnt`  out  CNTW  saturating count of bubbles inserted.

## Operation
- Qualified enable: `wen_q = wen_in & (dst_in[REGW-1:0] != 0)`. Writes to r0 never propagate.
- Normal edge, with `stall=0` and `flush=0`:
  - EX ← (`dst_in`, `wen_q`)
  - MEM ← EX
  - WB ← MEM
- `stall=1` and `flush=0`:
  - EX ← bubble (dst 0, wen 0).
  - MEM ← EX and WB ← MEM still advance.
  - `bubble_cnt` increments.
- `flush=1`, regardless of `stall`:
  - EX ← bubble and MEM ← bubble.
  - WB ← old MEM.
  - `bubble_cnt` is unchanged. Flush has priority over stall.
- `bubble_cnt` saturates at 2^CNTW−1 and does not wrap.
- Forwarding (combinational from the stage registers), evaluated for `fwd_a` against `src_a` and independently for `fwd_b` against `src_b`:
  - A source index of 0 gives 00.
  - Otherwise the priority is EX > MEM > WB. A stage matches when its `wen` is 1 and its `dst[REGW-1:0]` equals the source index.
  - If no stage matches, the result is 00.
- Upper bits of the destination (above REGW) are carried unchanged and ignored by the compares.

## Timing
- Reset (asynchronous, immediate): all `dst_*` = 0, all `wen_*` = 0, `bubble_cnt` = 0, so `fwd_a` = `fwd_b` = 00.
- Latency from `dst_in` to each stage output:
  - `dst_ex`: 1 cycle.
  - `dst_mem`: 2 cycles.
  - `dst_wb`: 3 cycles.
- Forwarding outputs are valid in the same cycle as their inputs. There is no registered delay on `fwd_*`.
- Stall and flush are sampled on the same edge that moves the data. There is no handshake, and the upstream stage holds its own registers during a stall.
- Reset asserted mid-pipeline clears all stages at once. The first load happens on the first rising edge after `rst` deasserts.
- Simultaneous `stall` and `flush`: flush behaviour applies, and the counter does not increment.
- Consecutive stalls:
  - Each stall inserts one bubble and increments the count by 1.
  - After 3 consecutive stalls, all three stages are bubbles.

## Test plan
- **Reset:** hold `rst` high while driving `dst_in=0x11`, `wen_in=1`, then release and hold `dst_in`/`wen_in` through the edges below.
  - While `rst` is high: all outputs are 0.
  - After the 1st edge: `dst_ex=0x11`, `wen_ex=1`.
  - After the 3rd edge: `dst_wb=0x11`, `wen_wb=1`.
- **r0 suppression:** `dst_in=0x20` (index 0), `wen_in=1` → `wen_ex=0`. With `src_a=0`, `fwd_a=00` on every cycle.
- **Forwarding priority:**
  - Issue writes to r5, r7 and r5 in back-to-back cycles.
  - With `src_a=5` and `src_b=7`: `fwd_a=01` (EX) and `fwd_b=10` (MEM).
  - One cycle later with no new write: `fwd_a=10`, `fwd_b=11`.
- **Stall:** issue r3 then assert `stall` for 1 cycle.
  - `dst_ex=0`, `wen_ex=0`, `dst_mem=3`.
  - `bubble_cnt=1`.
- **Flush beats stall:** issue r4 then r6, then assert `stall=1` and `flush=1` together.
  - EX and MEM become bubbles.
  - `dst_wb=4`.
  - `bubble_cnt` is unchanged.
- **Saturation:** with `CNTW=2`, apply 5 consecutive stalls → `bubble_cnt` reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/dst_pipe.sv
// Destination-register tracking through EX/MEM/WB with stall bubbles, flush,
// combinational operand-forwarding selects and a saturating bubble counter.
module dst_pipe #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dst_in,
  input  logic             wen_in,
  input  logic             stall,
  input  logic             flush,
  input  logic [REGW-1:0]  src_a,
  input  logic [REGW-1:0]  src_b,
  output logic [WIDTH-1:0] dst_ex,
  output logic [WIDTH-1:0] dst_mem,
  output logic [WIDTH-1:0] dst_wb,
  output logic             wen_ex,
  output logic             wen_mem,
  output logic             wen_wb,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNTW-1:0]  bubble_cnt
);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  // A zero index is the hardwired r0 and never needs forwarding.
  function automatic logic [1:0] fwd_sel(
    input logic [REGW-1:0] src,
    input logic            w_ex,  input logic [REGW-1:0] d_ex,
    input logic            w_mem, input logic [REGW-1:0] d_mem,
    input logic            w_wb,  input logic [REGW-1:0] d_wb
  );
    if (src == '0)                  return 2'b00;
    else if (w_ex  && d_ex  == src) return 2'b01;
    else if (w_mem && d_mem == src) return 2'b10;
    else if (w_wb  && d_wb  == src) return 2'b11;
    else                            return 2'b00;
  endfunction

  logic wen_q;
  assign wen_q = wen_in & (dst_in[REGW-1:0] != '0);

  // Decode -> EX -> MEM -> WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_ex     <= '0;
      dst_mem    <= '0;
      dst_wb     <= '0;
      wen_ex     <= 1'b0;
      wen_mem    <= 1'b0;
      wen_wb     <= 1'b0;
      bubble_cnt <= '0;
    end else if (flush) begin
      dst_ex  <= '0;
      wen_ex  <= 1'b0;
      dst_mem <= '0;
      wen_mem <= 1'b0;
      dst_wb  <= dst_mem;
      wen_wb  <= wen_mem;
    end else begin
      dst_wb  <= dst_mem;
      wen_wb  <= wen_mem;
      dst_mem <= dst_ex;
      wen_mem <= wen_ex;
      if (stall) begin
        dst_ex     <= '0;
        wen_ex     <= 1'b0;
        bubble_cnt <= sat_inc(bubble_cnt);
      end else begin
        dst_ex <= dst_in;
        wen_ex <= wen_q;
      end
    end
  end

  assign fwd_a = fwd_sel(src_a, wen_ex, dst_ex[REGW-1:0], wen_mem, dst_mem[REGW-1:0],
                         wen_wb, dst_wb[REGW-1:0]);
  assign fwd_b = fwd_sel(src_b, wen_ex, dst_ex[REGW-1:0], wen_mem, dst_mem[REGW-1:0],
                         wen_wb, dst_wb[REGW-1:0]);

endmodule

// File: tb/tb_dst_pipe.sv
// Scoreboard bench for dst_pipe: stimulus queues cycle-tagged expectations,
// a negedge monitor compares them against the DUT outputs.
module tb_dst_pipe;

  localparam int WIDTH = 32;
  localparam int REGW  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] dst_in;
  logic             wen_in, stall, flush, stall2;
  logic [REGW-1:0]  src_a, src_b;
  logic [WIDTH-1:0] dst_ex, dst_mem, dst_wb;
  logic             wen_ex, wen_mem, wen_wb;
  logic [1:0]       fwd_a, fwd_b;
  logic [7:0]       bubble_cnt;

  logic [WIDTH-1:0] s_dst_ex, s_dst_mem, s_dst_wb;
  logic             s_wen_ex, s_wen_mem, s_wen_wb;
  logic [1:0]       s_fwd_a, s_fwd_b;
  logic [1:0]       s_cnt;

  dst_pipe #(.WIDTH(WIDTH), .REGW(REGW), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .dst_in(dst_in), .wen_in(wen_in), .stall(stall),
    .flush(flush), .src_a(src_a), .src_b(src_b), .dst_ex(dst_ex),
    .dst_mem(dst_mem), .dst_wb(dst_wb), .wen_ex(wen_ex), .wen_mem(wen_mem),
    .wen_wb(wen_wb), .fwd_a(fwd_a), .fwd_b(fwd_b), .bubble_cnt(bubble_cnt)
  );

  dst_pipe #(.WIDTH(WIDTH), .REGW(REGW), .CNTW(2)) dut_sat (
    .clk(clk), .rst(rst), .dst_in(dst_in), .wen_in(wen_in), .stall(stall2),
    .flush(1'b0), .src_a(src_a), .src_b(src_b), .dst_ex(s_dst_ex),
    .dst_mem(s_dst_mem), .dst_wb(s_dst_wb), .wen_ex(s_wen_ex), .wen_mem(s_wen_mem),
    .wen_wb(s_wen_wb), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .bubble_cnt(s_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {
    S_DST_EX, S_DST_MEM, S_DST_WB, S_WEN_EX, S_WEN_MEM, S_WEN_WB,
    S_FWD_A, S_FWD_B, S_CNT, S_SAT_CNT
  } sel_t;

  typedef struct {
    int          tag;
    sel_t        sel;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input sel_t s);
    case (s)
      S_DST_EX:  return dst_ex;
      S_DST_MEM: return dst_mem;
      S_DST_WB:  return dst_wb;
      S_WEN_EX:  return 32'(wen_ex);
      S_WEN_MEM: return 32'(wen_mem);
      S_WEN_WB:  return 32'(wen_wb);
      S_FWD_A:   return 32'(fwd_a);
      S_FWD_B:   return 32'(fwd_b);
      S_CNT:     return 32'(bubble_cnt);
      default:   return 32'(s_cnt);
    endcase
  endfunction

  // Monitor: every expectation tagged for this cycle is compared here.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].tag == cyc) begin
        n_cmp++;
        if (actual(sb[i].sel) !== sb[i].exp) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h",
                   sb[i].name, cyc, actual(sb[i].sel), sb[i].exp);
        end
        sb.delete(i);
      end else if (sb[i].tag < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: missed check at cyc %0d (now %0d)", sb[i].name, sb[i].tag, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int ofs, input sel_t s, input logic [31:0] v,
                           input string name);
    item_t it;
    it.tag = cyc + ofs; it.sel = s; it.exp = v; it.name = name;
    sb.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    rst = 1'b1; dst_in = 32'h11; wen_in = 1'b1; stall = 1'b0; flush = 1'b0;
    stall2 = 1'b0; src_a = '0; src_b = '0;
    step(); step();
    // Reset holds everything at zero despite active inputs
    expect_at(0, S_DST_EX, 0, "rst_dst_ex");
    expect_at(0, S_DST_WB, 0, "rst_dst_wb");
    expect_at(0, S_WEN_EX, 0, "rst_wen_ex");
    expect_at(0, S_FWD_A,  0, "rst_fwd_a");
    expect_at(0, S_CNT,    0, "rst_cnt");
    rst = 1'b0;
    expect_at(1, S_DST_EX, 32'h11, "load_dst_ex");
    expect_at(1, S_WEN_EX, 1, "load_wen_ex");
    expect_at(2, S_DST_MEM, 32'h11, "load_dst_mem");
    expect_at(3, S_DST_WB, 32'h11, "load_dst_wb");
    expect_at(3, S_WEN_WB, 1, "load_wen_wb");
    step(); step(); step();

    // r0 suppression; pipeline holds 0x11 everywhere
    dst_in = 32'h20; wen_in = 1'b1; src_a = 5'd0; src_b = 5'd17;
    expect_at(0, S_FWD_A, 0, "r0_fwd_a0");
    expect_at(0, S_FWD_B, 1, "r17_fwd_b_ex");
    expect_at(1, S_WEN_EX, 0, "r0_wen_ex");
    expect_at(1, S_DST_EX, 32'h20, "r0_dst_ex");
    expect_at(1, S_FWD_A, 0, "r0_fwd_a1");
    expect_at(1, S_FWD_B, 2, "r17_fwd_b_mem");
    expect_at(2, S_FWD_A, 0, "r0_fwd_a2");
    step();

    // Forwarding priority: r5, r7, r5
    dst_in = 32'd5; step();
    dst_in = 32'd7; step();
    dst_in = 32'd5; step();
    dst_in = '0; wen_in = 1'b0; src_a = 5'd5; src_b = 5'd7;
    expect_at(0, S_FWD_A, 1, "prio_fwd_a_ex");
    expect_at(0, S_FWD_B, 2, "prio_fwd_b_mem");
    expect_at(1, S_FWD_A, 2, "prio_fwd_a_mem");
    expect_at(1, S_FWD_B, 3, "prio_fwd_b_wb");
    step();

    // Stall after r3
    dst_in = 32'd3; wen_in = 1'b1; step();
    stall = 1'b1;
    expect_at(1, S_DST_EX, 0, "stall_dst_ex");
    expect_at(1, S_WEN_EX, 0, "stall_wen_ex");
    expect_at(1, S_DST_MEM, 3, "stall_dst_mem");
    expect_at(1, S_WEN_MEM, 1, "stall_wen_mem");
    expect_at(1, S_CNT, 1, "stall_cnt");
    step();
    stall = 1'b0;

    // Flush beats stall after r4, r6
    dst_in = 32'd4; step();
    dst_in = 32'd6; step();
    stall = 1'b1; flush = 1'b1;
    expect_at(1, S_DST_EX, 0, "flush_dst_ex");
    expect_at(1, S_WEN_EX, 0, "flush_wen_ex");
    expect_at(1, S_DST_MEM, 0, "flush_dst_mem");
    expect_at(1, S_WEN_MEM, 0, "flush_wen_mem");
    expect_at(1, S_DST_WB, 4, "flush_dst_wb");
    expect_at(1, S_WEN_WB, 1, "flush_wen_wb");
    expect_at(1, S_CNT, 1, "flush_cnt");
    step();
    stall = 1'b0; flush = 1'b0;

    // Upper bits carried, ignored by compare
    dst_in = 32'h1000_0009; wen_in = 1'b1; src_a = 5'd9;
    expect_at(0, S_FWD_A, 0, "hi_fwd_a_none");
    expect_at(1, S_DST_EX, 32'h1000_0009, "hi_dst_ex");
    expect_at(1, S_WEN_EX, 1, "hi_wen_ex");
    expect_at(1, S_FWD_A, 1, "hi_fwd_a_ex");
    step();

    // Saturation on the 2-bit counter instance
    stall2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_at(1, S_SAT_CNT, 32'(sat_exp[i]), $sformatf("sat_cnt_%0d", i));
      step();
    end
    stall2 = 1'b0;
    expect_at(0, S_CNT, 1, "sat_main_cnt_unchanged");
    step();

    // Asynchronous reset mid-pipeline
    #1 rst = 1'b1;
    expect_at(0, S_DST_EX, 0, "arst_dst_ex");
    expect_at(0, S_DST_MEM, 0, "arst_dst_mem");
    expect_at(0, S_WEN_WB, 0, "arst_wen_wb");
    expect_at(0, S_CNT, 0, "arst_cnt");
    expect_at(0, S_SAT_CNT, 0, "arst_sat_cnt");
    step();
    rst = 1'b0;

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d checks pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
